// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one SPI master among NREQ single-byte requesters.
// Define SPI_ARB_TIMEOUT_EN to abort a BUSY phase after TIMEOUT_CYC cycles with err=1, rdata=8'hFF.
module spi_bus_arbiter #(
    parameter int NREQ        = 4,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [2*NREQ-1:0]   req_mode,
    output logic [NREQ-1:0]     ack,
    output logic [7:0]          rdata,
    output logic                err,
    output logic                busy,
    output logic                m_start,
    output logic [7:0]          m_din,
    output logic                m_cpol,
    output logic                m_cpha,
    input  logic [7:0]          m_dout,
    input  logic                m_done,
    input  logic                m_ss_n,
    output logic [NREQ-1:0]     cs_n
);
    localparam int IW = $clog2(NREQ);
    localparam int GW = $clog2(GAP_CYC + 1);

    if (NREQ < 2 || NREQ > 8 || GAP_CYC < 1 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
        $error("spi_bus_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BUSY, S_DONE, S_GAP} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_gnt;
    logic [IW-1:0]   r_rr;
    logic [GW-1:0]   r_gap;
    logic            r_done_q;
    logic [NREQ-1:0] r_ack;
    logic [7:0]      r_rdata;
    logic            r_m_start;
    logic [7:0]      r_m_din;
    logic            r_m_cpol;
    logic            r_m_cpha;
    logic [IW-1:0]   w_pick;
    logic [IW-1:0]   w_cand;
    logic            w_any;
    logic            w_done_edge;

    // Scan downward so the lowest offset from the rr pointer is the last (winning) assignment.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_rr;
        w_cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = IW'((int'(r_rr) + k) % NREQ);
            if (req[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    assign w_done_edge = m_done & ~r_done_q;

`ifdef SPI_ARB_TIMEOUT_EN
    logic        r_err;
    logic [15:0] r_tcnt;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_rr      <= '0;
            r_gap     <= '0;
            r_done_q  <= 1'b0;
            r_ack     <= '0;
            r_rdata   <= '0;
            r_m_start <= 1'b0;
            r_m_din   <= '0;
            r_m_cpol  <= 1'b0;
            r_m_cpha  <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            r_err     <= 1'b0;
            r_tcnt    <= '0;
`endif
        end else begin
            r_done_q  <= m_done;
            r_m_start <= 1'b0;
            r_ack     <= '0;
            unique case (r_state)
                S_IDLE: if (w_any) begin
                    r_gnt                <= w_pick;
                    r_m_din              <= req_data[8*w_pick +: 8];
                    {r_m_cpol, r_m_cpha} <= req_mode[2*w_pick +: 2];
                    r_m_start            <= 1'b1;
                    r_state              <= S_LOAD;
                end
                S_LOAD: begin
`ifdef SPI_ARB_TIMEOUT_EN
                    r_tcnt  <= '0;
`endif
                    r_state <= S_BUSY;
                end
                S_BUSY: if (w_done_edge) begin
                    r_rdata      <= m_dout;
                    r_ack[r_gnt] <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                    r_err        <= 1'b0;
`endif
                    r_state      <= S_DONE;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (r_tcnt == 16'(TIMEOUT_CYC - 1)) begin
                    r_rdata      <= 8'hFF;
                    r_ack[r_gnt] <= 1'b1;
                    r_err        <= 1'b1;
                    r_state      <= S_DONE;
                end else begin
                    r_tcnt <= r_tcnt + 16'd1;
                end
`endif
                S_DONE: begin
                    r_rr    <= (r_gnt == IW'(NREQ - 1)) ? '0 : r_gnt + IW'(1);
                    r_gap   <= '0;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (r_gap == GW'(GAP_CYC - 1)) r_state <= S_IDLE;
                    else                           r_gap   <= r_gap + GW'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Only the granted slave follows the master's select, and only while the transfer is live.
    always_comb begin
        cs_n = '1;
        if (r_state == S_BUSY) cs_n[r_gnt] = m_ss_n;
    end

    assign ack     = r_ack;
    assign rdata   = r_rdata;
    assign busy    = (r_state != S_IDLE);
    assign m_start = r_m_start;
    assign m_din   = r_m_din;
    assign m_cpol  = r_m_cpol;
    assign m_cpha  = r_m_cpha;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed scenarios plus randomized requesters against a cycle-level model.
`timescale 1ns/1ps
module tb_spi_bus_arbiter;
    localparam int NREQ    = 4;
    localparam int GAP_CYC = 4;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMO     = 50;
    localparam bit TMO_EN  = 1'b1;
`else
    localparam int TMO     = 1024;
    localparam bit TMO_EN  = 1'b0;
`endif
    localparam int NEVER   = 1 << 30;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [8*NREQ-1:0]   req_data;
    logic [2*NREQ-1:0]   req_mode;
    logic [NREQ-1:0]     ack;
    logic [7:0]          rdata;
    logic                err;
    logic                busy;
    logic                m_start;
    logic [7:0]          m_din;
    logic                m_cpol;
    logic                m_cpha;
    logic [7:0]          m_dout;
    logic                m_done;
    logic                m_ss_n;
    logic [NREQ-1:0]     cs_n;

    spi_bus_arbiter #(.NREQ(NREQ), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_mode(req_mode),
        .ack(ack), .rdata(rdata), .err(err), .busy(busy), .m_start(m_start),
        .m_din(m_din), .m_cpol(m_cpol), .m_cpha(m_cpha), .m_dout(m_dout),
        .m_done(m_done), .m_ss_n(m_ss_n), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int         cyc, rr_m, w_m, s_cyc, ack_due, done_due, last_ack, done_hold, n_acks;
    bit         idle_prev, outstanding, done_sent;
    logic [7:0] exp_din, slv_val;
    logic [1:0] exp_mode;
    int         grants[$];
    int         gaps[$];
    // Stimulus knobs: 0 random requesters, 1 hold req after ack, 2 drop req after ack
    int         stim_mode, slv_delay_fix, slv_data_fix;
    bit         glitch_en;

    task automatic model_init();
        idle_prev   = 1'b1;
        outstanding = 1'b0;
        done_sent   = 1'b0;
        rr_m        = 0;
        last_ack    = -1;
        done_hold   = 0;
        ack_due     = NEVER;
        done_due    = NEVER;
        grants.delete();
        gaps.delete();
    endtask

    task automatic step();
        logic [NREQ-1:0] exp_cs, exp_ack;
        bit exp_start, idle_now;
        int ack_i;
        @(negedge clk);
        cyc++;
        ack_i = -1;

        exp_cs = '1;
        if (outstanding && m_ss_n == 1'b0 && cyc < ack_due) exp_cs[w_m] = 1'b0;
        chk("cs_n", cs_n, exp_cs);

        exp_ack = '0;
        if (outstanding && cyc == ack_due) begin
            exp_ack[w_m] = 1'b1;
            chk("rdata", rdata, done_sent ? slv_val : 8'hFF);
            chk("err", err, done_sent ? 1'b0 : 1'b1);
            ack_i       = w_m;
            outstanding = 1'b0;
            last_ack    = cyc;
            rr_m        = (w_m + 1) % NREQ;
            n_acks++;
            if (!done_sent) m_ss_n = 1'b1;
        end
        chk("ack", ack, exp_ack);

        exp_start = idle_prev && (req != '0);
        chk("m_start", m_start, exp_start);
        if (exp_start) begin
            w_m = -1;
            for (int k = 0; k < NREQ; k++)
                if (w_m < 0 && req[(rr_m + k) % NREQ]) w_m = (rr_m + k) % NREQ;
            exp_din  = req_data[8*w_m +: 8];
            exp_mode = req_mode[2*w_m +: 2];
            grants.push_back(w_m);
            if (last_ack >= 0) gaps.push_back(cyc - last_ack);
            outstanding = 1'b1;
            done_sent   = 1'b0;
            s_cyc       = cyc;
            ack_due     = TMO_EN ? cyc + TMO + 1 : NEVER;
            done_due    = (slv_delay_fix >= 0) ? cyc + slv_delay_fix : cyc + int'($urandom_range(3, 25));
            slv_val     = (slv_data_fix >= 0) ? 8'(slv_data_fix) : 8'($urandom);
            m_ss_n      = 1'b0;
        end

        idle_now  = exp_start ? 1'b0 : (idle_prev || (last_ack >= 0 && cyc == last_ack + GAP_CYC + 1));
        chk("busy", busy, !idle_now);
        idle_prev = idle_now;

        if (outstanding) begin
            chk("m_din", m_din, exp_din);
            chk("m_cpol", m_cpol, exp_mode[1]);
            chk("m_cpha", m_cpha, exp_mode[0]);
        end

        // SPI master stand-in: done is a pulse or a short level
        if (m_done) begin
            done_hold--;
            if (done_hold <= 0) m_done = 1'b0;
        end
        if (outstanding && !done_sent && cyc == done_due && cyc + 1 <= ack_due) begin
            m_done    = 1'b1;
            done_hold = int'($urandom_range(1, 3));
            m_dout    = slv_val;
            m_ss_n    = 1'b1;
            done_sent = 1'b1;
            ack_due   = cyc + 1;
        end else if (glitch_en && !outstanding && !m_done && $urandom_range(0, 7) == 0) begin
            m_done    = 1'b1;
            done_hold = 1;
            m_dout    = 8'($urandom);
        end

        if (ack_i >= 0) begin
            if (stim_mode == 2 || (stim_mode == 0 && $urandom_range(0, 1) == 0)) req[ack_i] = 1'b0;
            else if (stim_mode == 0) begin
                req_data[8*ack_i +: 8] = 8'($urandom);
                req_mode[2*ack_i +: 2] = 2'($urandom);
            end
        end
        if (stim_mode == 0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && i != ack_i && $urandom_range(0, 5) == 0) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                    req_mode[2*i +: 2] = 2'($urandom);
                end else if (req[i] && $urandom_range(0, 15) == 0) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    req_mode[2*i +: 2] = 2'($urandom);
                end
                if (outstanding && i == w_m && $urandom_range(0, 31) == 0) req[i] = 1'b0;
            end
        end
    endtask

    task automatic run_acks(input int n, input int budget);
        int target;
        int k;
        target = n_acks + n;
        k = 0;
        while (n_acks < target && k < budget) begin
            step();
            k++;
        end
        if (n_acks < target) chk("ack_budget", n_acks, target);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        req = '0;
        m_done = 1'b0;
        m_ss_n = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_init();
    endtask

    initial begin
        cyc = 0; n_acks = 0; w_m = 0; s_cyc = 0;
        stim_mode = 2; slv_delay_fix = -1; slv_data_fix = -1; glitch_en = 1'b0;
        reset = 1'b0; req = '1; req_data = 32'h1122_3344; req_mode = 8'hE4;
        m_dout = '0; m_done = 1'b0; m_ss_n = 1'b1;
        model_init();

        // Reset held with every requester asserted
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 4'hF);
        chk("rst_m_start", m_start, 1'b0);
        chk("rst_ack", ack, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_m_din", m_din, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_err", err, 1'b0);

        // Single transfer from requester 2
        apply_reset();
        req = 4'b0100; req_data[23:16] = 8'hA5; req_mode[5:4] = 2'b11;
        slv_data_fix = 8'h3C; slv_delay_fix = 10;
        run_acks(1, 100);
        if (grants.size() > 0) chk("single_grant", grants[0], 2);
        chk("single_rdata", rdata, 8'h3C);

        // Round robin with all requesters held, done 20 cycles after each start
        apply_reset();
        stim_mode = 1; slv_data_fix = -1; slv_delay_fix = 20; glitch_en = 1'b1;
        for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = 8'($urandom);
        req = 4'hF;
        run_acks(5, 400);
        if (grants.size() >= 5) begin
            chk("rr_g0", grants[0], 0);
            chk("rr_g1", grants[1], 1);
            chk("rr_g2", grants[2], 2);
            chk("rr_g3", grants[3], 3);
            chk("rr_g4", grants[4], 0);
        end
        foreach (gaps[i]) chk("rr_gap", gaps[i], GAP_CYC + 2);

        // Reset five cycles into BUSY, then a fresh requester 1
        apply_reset();
        stim_mode = 2; glitch_en = 1'b0; slv_delay_fix = 30;
        req = 4'b0001;
        for (int k = 0; k < 100 && !(outstanding && cyc == s_cyc + 5); k++) step();
        chk("mid_in_busy", outstanding, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mid_cs_n", cs_n, 4'hF);
        chk("mid_m_start", m_start, 1'b0);
        chk("mid_ack", ack, 4'h0);
        chk("mid_busy", busy, 1'b0);
        m_ss_n = 1'b1; m_done = 1'b0; req = 4'b0010; req_data[15:8] = 8'h5A;
        @(negedge clk);
        chk("mid_ack_hold", ack, 4'h0);
        reset = 1'b1;
        model_init();
        slv_delay_fix = 8;
        run_acks(1, 100);
        if (grants.size() > 0) chk("mid_first", grants[0], 1);

        // m_done pulses while idle must be ignored
        req = '0;
        repeat (2) step();
        m_done = 1'b1; done_hold = 1;
        repeat (4) step();

`ifdef SPI_ARB_TIMEOUT_EN
        // Master never answers: both queued requesters time out in order
        apply_reset();
        stim_mode = 2; slv_delay_fix = NEVER;
        req = 4'b1100;
        run_acks(2, 300);
        if (grants.size() >= 2) begin
            chk("tmo_g0", grants[0], 2);
            chk("tmo_g1", grants[1], 3);
        end
`endif

        // Randomized traffic with glitches and level/pulse done
        apply_reset();
        stim_mode = 0; glitch_en = 1'b1; slv_delay_fix = -1; slv_data_fix = -1;
        repeat (3000) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
